// File: rtl/vc_requester_pkg.sv
// vc_requester_pkg: shared FSM state and flit layout for the requester
package vc_requester_pkg;
  localparam int FLIT_W_DEF = 32;
  typedef enum logic {IDLE = 1'b0, BODY = 1'b1} state_e;
  typedef struct packed {
    logic                  tail;
    logic [FLIT_W_DEF-1:0] data;
  } flit_t;
endpackage

// File: rtl/vc_requester_fifo_sync.sv
// fifo_sync: ce-gated synchronous FIFO, async active-low reset
module fifo_sync #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         ce,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;
  // full/empty come from the registered count, so a same-cycle pop never frees a slot
  always_comb begin
    do_push = ce & push & ~full;
    do_pop  = ce & pop & ~empty;
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= wdata;
  assign rdata = mem_q[rd_q];
  assign empty = cnt_q == '0;
  assign full  = cnt_q == (AW+1)'(DEPTH);
endmodule

// File: rtl/vc_requester.sv
// vc_requester: buffers flits, tracks credits, requests the arbiter and launches on grant.
// Optional stall counter output enabled by VC_REQ_STALL_COUNT_EN.
module vc_requester
  import vc_requester_pkg::*;
#(
  parameter int FLIT_W  = FLIT_W_DEF,
  parameter int DEPTH   = 4,
  parameter int CREDITS = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         ce,
  input  logic [FLIT_W-1:0]            i_data,
  input  logic                         i_tail,
  input  logic                         i_valid,
  output logic                         o_ready,
  output logic                         o_request,
  input  logic                         i_grant,
  output logic [FLIT_W-1:0]            o_data,
  output logic                         o_tail,
  output logic                         o_valid,
  input  logic                         i_credit,
  output logic [$clog2(CREDITS+1)-1:0] o_credits,
  output logic                         o_pkt_active,
  output logic                         o_credit_err
`ifdef VC_REQ_STALL_COUNT_EN
  ,
  output logic [15:0]                  o_stall_cnt
`endif
);
  localparam int CW = $clog2(CREDITS+1);
  localparam logic [CW-1:0] CMAX = CW'(CREDITS);
  logic [FLIT_W:0]   head;
  logic              empty, full, fire, cred_full;
  logic [CW-1:0]     cred_q, cred_d;
  logic              err_q, err_d, valid_q, valid_d, tail_q, tail_d;
  logic [FLIT_W-1:0] data_q, data_d;
  state_e            state_q, state_d;
  fifo_sync #(.W(FLIT_W+1), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .ce     (ce),
    .push   (i_valid),
    .pop    (fire),
    .wdata  ({i_tail, i_data}),
    .rdata  (head),
    .empty  (empty),
    .full   (full)
  );
  always_comb begin
    o_request = ~empty & (cred_q != '0);
    fire      = ce & o_request & i_grant;
    cred_full = cred_q == CMAX;
    cred_d    = ~ce ? cred_q :
                fire & ~i_credit ? cred_q - CW'(1) :
                ~fire & i_credit & ~cred_full ? cred_q + CW'(1) : cred_q;
    err_d     = err_q | (ce & i_credit & ~fire & cred_full);
    state_d   = fire ? (head[FLIT_W] ? IDLE : BODY) : state_q;
    valid_d   = ce ? fire : valid_q;
    data_d    = fire ? head[FLIT_W-1:0] : data_q;
    tail_d    = fire ? head[FLIT_W] : tail_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cred_q  <= CMAX;
      err_q   <= 1'b0;
      state_q <= IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      tail_q  <= 1'b0;
    end else begin
      cred_q  <= cred_d;
      err_q   <= err_d;
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      tail_q  <= tail_d;
    end
`ifdef VC_REQ_STALL_COUNT_EN
  logic [15:0] stall_q, stall_d;
  always_comb
    stall_d = ce & o_request & ~i_grant & (stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) stall_q <= '0;
    else stall_q <= stall_d;
  assign o_stall_cnt = stall_q;
`endif
  assign o_ready      = ~full;
  assign o_credits    = cred_q;
  assign o_credit_err = err_q;
  assign o_pkt_active = state_q == BODY;
  assign o_valid      = valid_q;
  assign o_data       = data_q;
  assign o_tail       = tail_q;
endmodule

// File: tb/tb_vc_requester.sv
// tb_vc_requester: directed self-checking bench for vc_requester
module tb_vc_requester;
  logic        clk = 1'b0;
  logic        reset_n, ce, i_tail, i_valid, i_grant, i_credit;
  logic [31:0] i_data, o_data;
  logic        o_ready, o_request, o_tail, o_valid, o_pkt_active, o_credit_err;
  logic [2:0]  o_credits;
`ifdef VC_REQ_STALL_COUNT_EN
  logic [15:0] o_stall_cnt;
`endif
  int vecs = 0;
  int errs = 0;
  vc_requester dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .i_data(i_data), .i_tail(i_tail),
    .i_valid(i_valid), .o_ready(o_ready), .o_request(o_request), .i_grant(i_grant),
    .o_data(o_data), .o_tail(o_tail), .o_valid(o_valid), .i_credit(i_credit),
    .o_credits(o_credits), .o_pkt_active(o_pkt_active), .o_credit_err(o_credit_err)
`ifdef VC_REQ_STALL_COUNT_EN
    , .o_stall_cnt(o_stall_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] d, input logic t);
    i_valid = 1'b1;
    i_data  = d;
    i_tail  = t;
  endtask
  task automatic refill(input int n);
    i_grant  = 1'b0;
    i_credit = 1'b1;
    repeat (n) step();
    i_credit = 1'b0;
  endtask
  initial begin
    reset_n = 1'b0; ce = 1'b1; i_data = '0; i_tail = 1'b0;
    i_valid = 1'b0; i_grant = 1'b0; i_credit = 1'b0;
    repeat (2) step();
    chk("rst_ready", o_ready, 1);
    chk("rst_req", o_request, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_tail", o_tail, 0);
    chk("rst_cred", o_credits, 4);
    chk("rst_act", o_pkt_active, 0);
    chk("rst_err", o_credit_err, 0);
    reset_n = 1'b1;
    step();
    // three-flit packet with grant held high
    i_grant = 1'b1;
    push(32'hD000_0000, 0); step();
    chk("pkt_req", o_request, 1);
    push(32'hD000_0001, 0); step();
    chk("pkt0_valid", o_valid, 1);
    chk("pkt0_data", o_data, 32'hD000_0000);
    chk("pkt0_act", o_pkt_active, 1);
    chk("pkt0_cred", o_credits, 3);
    push(32'hD000_0002, 1); step();
    chk("pkt1_data", o_data, 32'hD000_0001);
    chk("pkt1_act", o_pkt_active, 1);
    chk("pkt1_cred", o_credits, 2);
    i_valid = 1'b0; step();
    chk("pkt2_valid", o_valid, 1);
    chk("pkt2_data", o_data, 32'hD000_0002);
    chk("pkt2_tail", o_tail, 1);
    chk("pkt2_act", o_pkt_active, 0);
    chk("pkt2_cred", o_credits, 1);
    step();
    chk("pkt_idle_valid", o_valid, 0);
    chk("pkt_idle_req", o_request, 0);
    refill(3);
    chk("refill_cred", o_credits, 4);
    chk("refill_err", o_credit_err, 0);
    // credit starvation
    i_grant = 1'b1;
    for (int k = 0; k < 5; k++) begin
      push(32'h5000_0000 + k, 1); step();
    end
    i_valid = 1'b0;
    chk("starve_cred", o_credits, 0);
    chk("starve_req", o_request, 0);
    chk("starve_last", o_data, 32'h5000_0003);
    step();
    chk("starve_valid", o_valid, 0);
    chk("starve_req2", o_request, 0);
    i_credit = 1'b1; step(); i_credit = 1'b0;
    chk("starve_cred1", o_credits, 1);
    chk("starve_req1", o_request, 1);
    step();
    chk("starve_fire", o_valid, 1);
    chk("starve_data", o_data, 32'h5000_0004);
    chk("starve_act", o_pkt_active, 0);
    refill(4);
    // full FIFO, fifth flit dropped
    for (int k = 0; k < 5; k++) begin
      push(32'hF000_0000 + k, k == 3); step();
      chk($sformatf("full_ready%0d", k), o_ready, k < 3);
    end
    i_valid = 1'b0;
    chk("full_req", o_request, 1);
    i_grant = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("full_valid%0d", k), o_valid, 1);
      chk($sformatf("full_data%0d", k), o_data, 32'hF000_0000 + k);
    end
    step();
    chk("full_no5th", o_valid, 0);
    chk("full_cred", o_credits, 0);
    refill(4);
    // simultaneous fire and credit, then saturation
    i_grant = 1'b1;
    push(32'hA000_0000, 1); step();
    push(32'hA000_0001, 1); step();
    i_valid = 1'b0; step();
    chk("sim_cred2", o_credits, 2);
    push(32'hA000_0002, 1); step();
    i_valid = 1'b0; i_credit = 1'b1; step();
    chk("sim_cred_hold", o_credits, 2);
    chk("sim_data", o_data, 32'hA000_0002);
    i_grant = 1'b0; step();
    chk("sat_cred3", o_credits, 3);
    step();
    chk("sat_cred4", o_credits, 4);
    chk("sat_err0", o_credit_err, 0);
    step();
    chk("sat_cred", o_credits, 4);
    chk("sat_err1", o_credit_err, 1);
    i_credit = 1'b0; step();
    chk("sat_sticky", o_credit_err, 1);
    // asynchronous reset mid-packet
    push(32'hC000_0000, 0); step();
    push(32'hC000_0001, 0); step();
    push(32'hC000_0002, 1); step();
    i_valid = 1'b0; i_grant = 1'b1; step();
    chk("mid_act", o_pkt_active, 1);
    chk("mid_data", o_data, 32'hC000_0000);
    chk("mid_cred", o_credits, 3);
    i_grant = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", o_valid, 0);
    chk("arst_data", o_data, 0);
    chk("arst_tail", o_tail, 0);
    chk("arst_act", o_pkt_active, 0);
    chk("arst_cred", o_credits, 4);
    chk("arst_err", o_credit_err, 0);
    chk("arst_req", o_request, 0);
    chk("arst_ready", o_ready, 1);
    step();
    reset_n = 1'b1;
    step();
    chk("post_empty", o_request, 0);
    push(32'hBEEF_0001, 1); step();
    i_valid = 1'b0;
`ifdef VC_REQ_STALL_COUNT_EN
    repeat (10) step();
    chk("stall_cnt", o_stall_cnt, 10);
`endif
    i_grant = 1'b1; step();
    chk("post_data", o_data, 32'hBEEF_0001);
    // clock enable gating
    i_grant = 1'b0;
    push(32'hCE00_0001, 1); step();
    i_valid = 1'b0;
    ce = 1'b0; i_grant = 1'b1; step();
    chk("ce_off_valid", o_valid, 0);
    chk("ce_off_req", o_request, 1);
    chk("ce_off_cred", o_credits, 3);
    ce = 1'b1; step();
    chk("ce_on_valid", o_valid, 1);
    chk("ce_on_data", o_data, 32'hCE00_0001);
    chk("ce_on_cred", o_credits, 2);
    ce = 1'b0; i_grant = 1'b0; step();
    chk("ce_hold_valid", o_valid, 1);
    ce = 1'b1; step();
    chk("ce_clear_valid", o_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
